data_memory_dump: RTL

//  Read-side initiator for the pipeline data memory. On a start pulse, walks the data memory

---
 rtl/data_memory_dump_pkg.sv | 26 ++
 rtl/data_memory_dump.sv | 121 ++++++++++++
 2 files changed

// File: rtl/data_memory_dump_pkg.sv
// Shared debug-unit definitions: dump/command FSM state encodings and word/byte sizing helpers.
package data_memory_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_NEXT = 3'd4,
    ST_DONE = 3'd5
  } dump_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_BYTE_WIDTH = 8;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / DEFAULT_BYTE_WIDTH;

  function automatic int bytes_per_word(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // A single-byte word still needs a 1-bit index so the register has a legal width.
  function automatic int byte_idx_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/data_memory_dump.sv
// Debug memory dump: walks data memory words 0..N_WORDS-1 and streams each word
// LSB-first, one byte per transmitter handshake. Pipeline must be halted while busy.
module data_memory_dump
  import data_memory_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int N_WORDS    = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  i_tx_done,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_valid,
  output logic                  o_mem_read_enable,
  output logic                  o_mem_write_enable,
  output logic [BYTE_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int                    BPW       = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
  localparam int                    IDX_W     = byte_idx_width(BPW);
  localparam logic [IDX_W-1:0]      LAST_BYTE = IDX_W'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_WORDS - 1);

  dump_state_e           state_r;
  dump_state_e           next_state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [IDX_W-1:0]      byte_idx_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic [BYTE_WIDTH-1:0] tx_byte_s;

  assign tx_byte_s = word_r[int'(byte_idx_r) * BYTE_WIDTH +: BYTE_WIDTH];

  // State register plus the address/byte cursor and captured word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      byte_idx_r <= '0;
      word_r     <= '0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        ST_READ: word_r <= i_read_data;
        ST_NEXT: begin
          if (byte_idx_r < LAST_BYTE) begin
            byte_idx_r <= byte_idx_r + IDX_W'(1);
          end else if (addr_r < LAST_ADDR) begin
            addr_r     <= addr_r + ADDR_WIDTH'(1);
            byte_idx_r <= '0;
          end else begin
            byte_idx_r <= byte_idx_r;
          end
        end
        ST_DONE: begin
          addr_r     <= '0;
          byte_idx_r <= '0;
        end
        default: begin
          word_r <= word_r;
        end
      endcase
    end
  end

  // Next-state decode; i_start and i_tx_done only matter in IDLE and WAIT respectively.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) next_state_s = ST_READ;
        else         next_state_s = ST_IDLE;
      end
      ST_READ: next_state_s = ST_SEND;
      ST_SEND: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) next_state_s = ST_NEXT;
        else           next_state_s = ST_WAIT;
      end
      ST_NEXT: begin
        if (byte_idx_r < LAST_BYTE)  next_state_s = ST_SEND;
        else if (addr_r < LAST_ADDR) next_state_s = ST_READ;
        else                         next_state_s = ST_DONE;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Moore output decode from state and registers only.
  always_comb begin
    o_mem_address      = addr_r;
    o_mem_valid        = 1'b0;
    o_mem_read_enable  = 1'b0;
    o_mem_write_enable = 1'b0;
    o_tx_data          = '0;
    o_tx_start         = 1'b0;
    o_busy             = (state_r != ST_IDLE);
    o_done             = 1'b0;
    case (state_r)
      ST_READ: begin
        o_mem_valid       = 1'b1;
        o_mem_read_enable = 1'b1;
      end
      ST_SEND: begin
        o_tx_start = 1'b1;
        o_tx_data  = tx_byte_s;
      end
      ST_WAIT: o_tx_data = tx_byte_s;
      ST_DONE: o_done = 1'b1;
      default: o_tx_start = 1'b0;
    endcase
  end

endmodule
